// File: rtl/bcd_second_counter_pkg.sv
// second_counter_pkg: shared constants for the BCD seconds counter.
//   - FSM state encoding (ST_IDLE / ST_RUN / ST_PAUSE), also visible on state_out
//   - BCD digit width and per-digit maxima (decimal 9, MM:SS tens-of-seconds 5)
//   - digit_max(): maximum value for a given digit position
// Ports: none (package).
`timescale 1ns/1ps
package second_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam int DIGIT_W       = 4;
    localparam int DEC_MAX       = 9;
    localparam int MMSS_TENS_MAX = 5;

    // In MM:SS mode only digit 1 (tens of seconds) is modulo 6.
    function automatic int digit_max(input int idx, input bit mmss_en);
        return (mmss_en && idx == 1) ? MMSS_TENS_MAX : DEC_MAX;
    endfunction

endpackage

// File: rtl/bcd_second_counter_if.sv
// bcd_second_counter_if: control ticks in, BCD count and status out.
// Ports (signals):
//   enable_in      1 Hz count tick (one clock wide)
//   start_stop_in  run/pause toggle pulse
//   clear_in       zero the count and stop
//   bcd_out        packed BCD count, digit 0 in [3:0]
//   running_out    high while in RUN
//   wrap_out       one-cycle pulse on full -> zero
//   state_out      FSM state (IDLE=0, RUN=1, PAUSE=2)
// Modports: master drives the pulses, slave is the counter.
`timescale 1ns/1ps
interface bcd_second_counter_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      enable_in;
    logic                      start_stop_in;
    logic                      clear_in;
    logic [4*NUM_DIGITS-1:0]   bcd_out;
    logic                      running_out;
    logic                      wrap_out;
    logic [1:0]                state_out;

    modport master (
        output enable_in, start_stop_in, clear_in,
        input  bcd_out, running_out, wrap_out, state_out
    );

    modport slave (
        input  enable_in, start_stop_in, clear_in,
        output bcd_out, running_out, wrap_out, state_out
    );
endinterface

// File: rtl/bcd_second_counter_digit.sv
// bcd_digit: one BCD digit register that counts 0..MAX and rolls over.
// Ports:
//   clk_in, rst_n_in  clock, async active-low reset
//   inc_in            advance this digit by one
//   clr_in            synchronous clear to zero (wins over inc_in)
//   digit_out         current digit value
//   carry_out         inc_in while at MAX (next digit should advance)
`timescale 1ns/1ps
module bcd_digit
    import second_counter_pkg::*;
#(
    parameter int MAX = DEC_MAX
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               inc_in,
    input  logic               clr_in,
    output logic [DIGIT_W-1:0] digit_out,
    output logic               carry_out
);
    localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MAX);

    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic               at_max;

    // >= rather than == so a corrupted digit still returns to zero.
    assign at_max = (digit_q >= MAX_V);

    always_comb begin
        digit_d = digit_q;
        if (clr_in) begin
            digit_d = '0;
        end else if (inc_in) begin
            digit_d = at_max ? '0 : digit_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_out = digit_q;
    assign carry_out = inc_in & at_max;
endmodule

// File: rtl/bcd_second_counter.sv
// bcd_second_counter: run/pause/clear BCD seconds counter.
// Ports:
//   clk_in    100 MHz system clock, rising edge
//   rst_n_in  asynchronous active-low reset
//   bus       bcd_second_counter_if.slave (ticks in, count/status out)
// Parameter NUM_DIGITS (1..8) sets the number of BCD digits.
// Macro COUNTER_MMSS_EN: when defined, digit 1 counts 0..5 (MM:SS display)
// and NUM_DIGITS must be at least 2; otherwise every digit is decimal.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | cleared, ticks ignored, waiting for start
// ST_RUN   | each enable_in tick advances the count
// ST_PAUSE | count held, ticks ignored, start resumes
`timescale 1ns/1ps
module bcd_second_counter
    import second_counter_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    bcd_second_counter_if.slave  bus
);

`ifdef COUNTER_MMSS_EN
    localparam bit MMSS_EN = 1'b1;
    if (NUM_DIGITS < 2) begin : g_bad_mmss
        $error("bcd_second_counter: MM:SS mode needs NUM_DIGITS >= 2");
    end
`else
    localparam bit MMSS_EN = 1'b0;
`endif

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_width
        $error("bcd_second_counter: NUM_DIGITS must be 1..8");
    end

    state_e state_q, state_d;
    logic   running_q, running_d;
    logic   wrap_q, wrap_d;

    logic [DIGIT_W*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS:0]           carry;

    // Tick is applied before any start_stop in the same cycle, so the
    // increment qualifies on the current state; clear kills it.
    assign carry[0] = (state_q == ST_RUN) & bus.enable_in & ~bus.clear_in;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit #(
            .MAX (digit_max(g, MMSS_EN))
        ) u_digit (
            .clk_in    (clk_in),
            .rst_n_in  (rst_n_in),
            .inc_in    (carry[g]),
            .clr_in    (bus.clear_in),
            .digit_out (digits[g*DIGIT_W +: DIGIT_W]),
            .carry_out (carry[g+1])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start_stop_in) state_d = ST_RUN;
            ST_RUN:   if (bus.start_stop_in) state_d = ST_PAUSE;
            ST_PAUSE: if (bus.start_stop_in) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
        if (bus.clear_in) begin
            state_d = ST_IDLE;
        end
        running_d = (state_d == ST_RUN);
        // Carry out of the top digit only happens on the full -> zero tick;
        // carry[0] already excludes clear, so a cleared wrap never pulses.
        wrap_d    = carry[NUM_DIGITS];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bus.bcd_out     = digits;
    assign bus.state_out   = state_q;
    assign bus.running_out = running_q;
    assign bus.wrap_out    = wrap_q;
endmodule

// File: tb/tb_bcd_second_counter.sv
// Testbench for bcd_second_counter. The reference keeps the count as a plain
// integer (seconds or ticks) and converts it to mixed-radix BCD for comparison.
// Build with +define+COUNTER_MMSS_EN to exercise the MM:SS configuration.
`timescale 1ns/1ps
module tb_bcd_second_counter;
    localparam int ND = 4;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b1;
    always #5 clk_in = ~clk_in;

    bcd_second_counter_if #(.NUM_DIGITS(ND)) bus ();

    bcd_second_counter #(.NUM_DIGITS(ND)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    int m_cnt;   // count value as an integer
    int m_st;    // 0 idle, 1 run, 2 pause
    bit m_wrap;

    function automatic int radix(input int i);
`ifdef COUNTER_MMSS_EN
        return (i == 1) ? 6 : 10;
`else
        return 10;
`endif
    endfunction

    function automatic int full_count();
        int p = 1;
        for (int i = 0; i < ND; i++) p = p * radix(i);
        return p;
    endfunction

    function automatic logic [4*ND-1:0] enc(input int v);
        logic [4*ND-1:0] r = '0;
        int x = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(x % radix(i));
            x = x / radix(i);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_bcd"},   32'(bus.bcd_out),     32'(enc(m_cnt)));
        check({tag, "_state"}, 32'(bus.state_out),   32'(m_st));
        check({tag, "_run"},   32'(bus.running_out), 32'(m_st == 1));
        check({tag, "_wrap"},  32'(bus.wrap_out),    32'(m_wrap));
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_st   = 0;
        m_wrap = 1'b0;
    endtask

    task automatic step(input bit en, input bit ss, input bit clr, input string tag);
        @(negedge clk_in);
        bus.enable_in     = en;
        bus.start_stop_in = ss;
        bus.clear_in      = clr;
        @(posedge clk_in);
        #1;
        bus.enable_in     = 1'b0;
        bus.start_stop_in = 1'b0;
        bus.clear_in      = 1'b0;
        m_wrap = 1'b0;
        if (clr) begin
            m_cnt = 0;
            m_st  = 0;
        end else begin
            if (m_st == 1 && en) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == full_count()) begin
                    m_cnt  = 0;
                    m_wrap = 1'b1;
                end
            end
            if (ss) m_st = (m_st == 1) ? 2 : 1;
        end
        check_all(tag);
    endtask

    task automatic tick_until(input logic [4*ND-1:0] target, input string tag);
        int guard = 0;
        while (enc(m_cnt) !== target && guard < 20000) begin
            step(1'b1, 1'b0, 1'b0, tag);
            guard++;
        end
        check({tag, "_reached"}, 32'(bus.bcd_out), 32'(target));
    endtask

    initial begin
        bus.enable_in     = 1'b0;
        bus.start_stop_in = 1'b0;
        bus.clear_in      = 1'b0;
        model_reset();

        // Reset state
        #2 rst_n_in = 1'b0;
        #6;
        check_all("reset");
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Ticks in IDLE are ignored
        repeat (3) step(1'b1, 1'b0, 1'b0, "idle_tick");
        check("idle_bcd", 32'(bus.bcd_out), 32'h0);
        check("idle_state", 32'(bus.state_out), 32'd0);

        // Start, then 12 ticks
        step(1'b0, 1'b1, 1'b0, "start");
        repeat (12) step(1'b1, 1'b0, 1'b0, "run12");
        check("run12_val", 32'(bus.bcd_out), 32'h0012);
        check("run12_running", 32'(bus.running_out), 32'd1);

        // Digit carries and full wrap (every step is checked on the way)
        tick_until(16'h0009, "to9");
        step(1'b1, 1'b0, 1'b0, "carry9");
        check("carry9_val", 32'(bus.bcd_out), 32'h0010);
`ifdef COUNTER_MMSS_EN
        tick_until(16'h0059, "to59");
        step(1'b1, 1'b0, 1'b0, "carry59");
        check("carry59_val", 32'(bus.bcd_out), 32'h0100);
        tick_until(16'h9959, "tofull");
`else
        tick_until(16'h0999, "to999");
        step(1'b1, 1'b0, 1'b0, "carry999");
        check("carry999_val", 32'(bus.bcd_out), 32'h1000);
        tick_until(16'h9999, "tofull");
`endif
        step(1'b1, 1'b0, 1'b0, "wrap");
        check("wrap_val", 32'(bus.bcd_out), 32'h0000);
        check("wrap_pulse", 32'(bus.wrap_out), 32'd1);
        check("wrap_state", 32'(bus.state_out), 32'd1);
        step(1'b0, 1'b0, 1'b0, "after_wrap");
        check("wrap_one_cycle", 32'(bus.wrap_out), 32'd0);

        // start_stop coinciding with a tick
        tick_until(16'h0042, "to42");
        step(1'b1, 1'b1, 1'b0, "ss_tick_run");
        check("ss_tick_run_val", 32'(bus.bcd_out), 32'h0043);
        check("ss_tick_run_state", 32'(bus.state_out), 32'd2);
        repeat (5) step(1'b1, 1'b0, 1'b0, "pause_tick");
        check("pause_hold", 32'(bus.bcd_out), 32'h0043);
        step(1'b1, 1'b1, 1'b0, "ss_tick_pause");
        check("resume_val", 32'(bus.bcd_out), 32'h0043);
        check("resume_state", 32'(bus.state_out), 32'd1);

        // Clear coinciding with a tick
`ifdef COUNTER_MMSS_EN
        tick_until(16'h0757, "to757");
`else
        tick_until(16'h0777, "to777");
`endif
        step(1'b1, 1'b0, 1'b1, "clr_tick");
        check("clr_val", 32'(bus.bcd_out), 32'h0);
        check("clr_state", 32'(bus.state_out), 32'd0);
        check("clr_wrap", 32'(bus.wrap_out), 32'd0);

        // Asynchronous reset between edges
        step(1'b0, 1'b1, 1'b0, "restart");
        tick_until(16'h0500, "to500");
        #2 rst_n_in = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        step(1'b0, 1'b1, 1'b0, "post_rst_start");
        step(1'b1, 1'b0, 1'b0, "post_rst_tick");
        check("post_rst_val", 32'(bus.bcd_out), 32'h0001);

        // Randomized control pulses
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 63) == 0),
                 "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
